keypad_scan: RTL and testbench

//  Scans a 4x4 matrix keypad and delivers debounced key codes to the core logic.

---
 rtl/keypad_scan.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Scans a 4x4 active-low matrix keypad and delivers debounced key codes.
//   Columns are driven low one at a time; the synchronised row lines are
//   sampled on the last dwell cycle of each column.  A full four-column
//   snapshot is classified once per frame and drives a press/release
//   debounce FSM.
//
//   Optional feature macro: KEYPAD_REPEAT_EN
//     defined   -> while a key is held, key_valid re-pulses every REPEAT_FR frames
//     undefined -> exactly one key_valid per accepted press
//
// Parameters
//   SCAN_N     width of the column dwell counter (dwell = 2^SCAN_N clk), >= 3
//   DB_COUNT   identical frames needed to accept a press or a release, 1..15
//   REPEAT_FR  frames between auto-repeat strobes (repeat build only)
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad columns, active-low, exactly one low at a time
//   key[3:0]   last accepted key code = row_idx*4 + col_idx
//   key_valid  one-clk strobe for a new key (or a repeat)
//   key_down   high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_N    = 16,
    parameter int DB_COUNT  = 4,
    parameter int REPEAT_FR = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] DB_CNT = DB_COUNT[3:0];

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FR + 1);
    localparam logic [REP_W-1:0] REP_LAST = REPEAT_FR[REP_W-1:0];
    logic [REP_W-1:0] rep_cnt_r;
`endif

    logic [3:0]        row_meta_r;
    logic [3:0]        row_sync_r;
    logic [SCAN_N-1:0] dwell_r;
    logic [1:0]        col_idx_r;
    // Columns 0..2 only: column 3 is consumed live on the evaluation cycle.
    logic [11:0]       snap_r;
    state_t            state_r;
    logic [3:0]        cand_r;
    logic [3:0]        cnt_r;

    logic              sample_s;
    logic              eval_s;
    logic [15:0]       frame_s;
    logic [4:0]        low_cnt_s;
    logic [3:0]        low_idx_s;
    logic              is_none_s;
    logic              is_single_s;
    logic [3:0]        single_key_s;

    // Active-low column drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] pat;
        case (c)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            default: pat = 4'b0111;
        endcase
        return pat;
    endfunction

    assign sample_s = &dwell_r;
    assign eval_s   = sample_s && (col_idx_r == 2'd3);
    // Snapshot bit index is col*4 + row.
    assign frame_s  = {row_sync_r, snap_r};

    // Classify the frame snapshot: count low bits and remember the last one.
    always_comb begin
        low_cnt_s = 5'd0;
        low_idx_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            low_cnt_s = low_cnt_s + {4'd0, ~frame_s[i]};
            if (!frame_s[i]) begin
                low_idx_s = 4'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    assign is_none_s    = (low_cnt_s == 5'd0);
    assign is_single_s  = (low_cnt_s == 5'd1);
    // Snapshot index {col,row} -> key code {row,col}.
    assign single_key_s = {low_idx_s[1:0], low_idx_s[3:2]};

    // Row synchroniser, column dwell timer, column drive and snapshot capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
            dwell_r    <= {SCAN_N{1'b0}};
            col_idx_r  <= 2'd0;
            col        <= 4'b1110;
            snap_r     <= 12'hFFF;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
            dwell_r    <= dwell_r + {{(SCAN_N-1){1'b0}}, 1'b1};
            if (sample_s) begin
                col_idx_r <= col_idx_r + 2'd1;
                col       <= col_drive(col_idx_r + 2'd1);
                case (col_idx_r)
                    2'd0:    snap_r[3:0]  <= row_sync_r;
                    2'd1:    snap_r[7:4]  <= row_sync_r;
                    2'd2:    snap_r[11:8] <= row_sync_r;
                    default: snap_r       <= snap_r;
                endcase
            end
        end
    end

    // Debounce FSM with registered key, key_valid and key_down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            cand_r    <= 4'd0;
            cnt_r     <= 4'd0;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r <= {REP_W{1'b0}};
`endif
        end else begin
            key_valid <= 1'b0;
            if (eval_s) begin
                case (state_r)
                    IDLE: begin
                        if (is_single_s) begin
                            cand_r <= single_key_s;
                            cnt_r  <= 4'd1;
                            if (DB_CNT == 4'd1) begin
                                state_r   <= HELD;
                                key       <= single_key_s;
                                key_down  <= 1'b1;
                                key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt_r <= {REP_W{1'b0}};
`endif
                            end else begin
                                state_r <= PRESS;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    PRESS: begin
                        if (is_single_s && (single_key_s == cand_r)) begin
                            cnt_r <= cnt_r + 4'd1;
                            if ((cnt_r + 4'd1) == DB_CNT) begin
                                state_r   <= HELD;
                                key       <= cand_r;
                                key_down  <= 1'b1;
                                key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt_r <= {REP_W{1'b0}};
`endif
                            end else begin
                                state_r <= PRESS;
                            end
                        end else if (is_single_s) begin
                            cand_r <= single_key_s;
                            cnt_r  <= 4'd1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    HELD: begin
                        if (is_none_s) begin
                            cnt_r <= 4'd1;
                            if (DB_CNT == 4'd1) begin
                                state_r  <= IDLE;
                                key_down <= 1'b0;
                            end else begin
                                state_r <= RELEASE;
                            end
                        end else begin
                            // No rollover: another key while held leaves key alone.
                            state_r <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            if ((rep_cnt_r + 1'b1) == REP_LAST) begin
                                rep_cnt_r <= {REP_W{1'b0}};
                                key_valid <= 1'b1;
                            end else begin
                                rep_cnt_r <= rep_cnt_r + 1'b1;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (is_none_s) begin
                            cnt_r <= cnt_r + 4'd1;
                            if ((cnt_r + 4'd1) == DB_CNT) begin
                                state_r  <= IDLE;
                                key_down <= 1'b0;
                            end else begin
                                state_r <= RELEASE;
                            end
                        end else begin
                            // Back to held without a new strobe; repeat count resumes.
                            state_r <= HELD;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//   Bench for keypad_scan with SCAN_N=3 (frame = 32 clk), DB_COUNT=2,
//   REPEAT_FR=4.  A behavioural keypad turns a 16-bit "pressed" mask into row
//   levels from the driven columns.  A table of steps drives the main cases;
//   hand-written sequences cover reset/scan order and reset during a hold.
//   Expected key codes are queued when a press is driven and popped when the
//   DUT strobes key_valid.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    logic       clk;
    logic       reset_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;
    int          n_checks;
    int          n_fail;
    int          strobe_cnt;
    logic        kv_prev;
    logic [3:0]  exp_q[$];

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic        exp_down;
        logic [3:0]  exp_key;
        int          exp_strobes;
    } step_t;

    step_t steps [18];
    logic [3:0] exp_col [4];
    int         rep_strobes;

    keypad_scan #(
        .SCAN_N   (3),
        .DB_COUNT (2),
        .REPEAT_FR(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row      (row),
        .col      (col),
        .key      (key),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (32 * n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Strobe monitor: width, scoreboard pop, and quiet during reset.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("kv_in_reset", {15'd0, key_valid}, 16'd0);
        end else if (key_valid) begin
            strobe_cnt++;
            check("kv_width", {15'd0, kv_prev}, 16'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {12'd0, key}, 16'hFFFF);
            end else begin
                check("sb_key", {12'd0, key}, {12'd0, exp_q.pop_front()});
                check("sb_down", {15'd0, key_down}, 16'd1);
            end
        end
        kv_prev = key_valid;
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        strobe_cnt = 0;
        kv_prev    = 1'b0;
        pressed    = 16'h0000;
        reset_n    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_strobes = 2;
`else
        rep_strobes = 1;
`endif

        exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        //            keys      fr  down  key    strobes
        steps[0]  = '{16'h0040, 2, 1'b1, 4'd6,  1};  // press 6
        steps[1]  = '{16'h0000, 1, 1'b1, 4'd6,  0};  // first empty frame
        steps[2]  = '{16'h0000, 1, 1'b0, 4'd6,  0};  // released, key kept
        steps[3]  = '{16'h0040, 1, 1'b0, 4'd6,  0};  // bounce 1 frame
        steps[4]  = '{16'h0000, 2, 1'b0, 4'd6,  0};
        steps[5]  = '{16'h0021, 2, 1'b0, 4'd6,  0};  // 0+5 MULTI
        steps[6]  = '{16'h0020, 1, 1'b0, 4'd6,  0};  // hold 5
        steps[7]  = '{16'h0020, 1, 1'b1, 4'd5,  1};
        steps[8]  = '{16'h0000, 2, 1'b0, 4'd5,  0};
        steps[9]  = '{16'h8000, 2, 1'b1, 4'd15, 1};  // key 15
        steps[10] = '{16'h8008, 1, 1'b1, 4'd15, 0};  // no rollover
        steps[11] = '{16'h0000, 2, 1'b0, 4'd15, 0};
        steps[12] = '{16'h1000, 1, 1'b0, 4'd15, 0};  // cand 12
        steps[13] = '{16'h0008, 1, 1'b0, 4'd15, 0};  // restart on 3
        steps[14] = '{16'h0008, 1, 1'b1, 4'd3,  1};
        steps[15] = '{16'h0000, 1, 1'b1, 4'd3,  0};  // release started
        steps[16] = '{16'h0008, 1, 1'b1, 4'd3,  0};  // key back: held, no strobe
        steps[17] = '{16'h0000, 2, 1'b0, 4'd3,  0};

        // Reset values while held in reset.
        repeat (5) @(negedge clk);
        check("rst_col", {12'd0, col}, 16'h000E);
        check("rst_key", {12'd0, key}, 16'd0);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_down", {15'd0, key_down}, 16'd0);
        reset_n = 1'b1;

        // Column order over the first (empty) frame, checked mid-dwell.
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("scan_col", {12'd0, col}, {12'd0, exp_col[i]});
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("scan_wrap", {12'd0, col}, 16'h000E);

        // Table-driven steps.
        for (int s = 0; s < 18; s++) begin
            pressed    = steps[s].keys;
            strobe_cnt = 0;
            if (steps[s].exp_strobes > 0) exp_q.push_back(steps[s].exp_key);
            wait_frames(steps[s].frames);
            check($sformatf("step%0d_down", s), {15'd0, key_down}, {15'd0, steps[s].exp_down});
            check($sformatf("step%0d_key", s), {12'd0, key}, {12'd0, steps[s].exp_key});
            check($sformatf("step%0d_strobes", s), 16'(strobe_cnt), 16'(steps[s].exp_strobes));
            check($sformatf("step%0d_sb_empty", s), 16'(exp_q.size()), 16'd0);
        end

        // Hold key 9 with a reset pulse in the middle of the hold.
        pressed    = 16'h0200;
        strobe_cnt = 0;
        for (int i = 0; i < rep_strobes; i++) exp_q.push_back(4'd9);
        wait_frames(7);
        check("hold9_strobes", 16'(strobe_cnt), 16'(rep_strobes));
        check("hold9_down", {15'd0, key_down}, 16'd1);
        check("hold9_key", {12'd0, key}, 16'd9);

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_down", {15'd0, key_down}, 16'd0);
        check("midrst_key", {12'd0, key}, 16'd0);
        check("midrst_col", {12'd0, col}, 16'h000E);
        reset_n    = 1'b1;
        strobe_cnt = 0;
        for (int i = 0; i < rep_strobes; i++) exp_q.push_back(4'd9);
        wait_frames(1);
        check("reacc_early", {15'd0, key_down}, 16'd0);
        wait_frames(6);
        check("reacc_strobes", 16'(strobe_cnt), 16'(rep_strobes));
        check("reacc_down", {15'd0, key_down}, 16'd1);
        check("reacc_key", {12'd0, key}, 16'd9);
        check("reacc_sb_empty", 16'(exp_q.size()), 16'd0);

        pressed = 16'h0000;
        wait_frames(2);
        check("final_down", {15'd0, key_down}, 16'd0);
        check("final_key", {12'd0, key}, 16'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
